// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp patterns for the two-way intersection controller.
package traffic_pkg;

  // Phase encoding: all 3-bit codes are used, so no unreachable code exists.
  localparam logic [2:0] S_NS_GREEN  = 3'd0;
  localparam logic [2:0] S_NS_YELLOW = 3'd1;
  localparam logic [2:0] S_ALLRED_A  = 3'd2;
  localparam logic [2:0] S_WALK_A    = 3'd3;
  localparam logic [2:0] S_EW_GREEN  = 3'd4;
  localparam logic [2:0] S_EW_YELLOW = 3'd5;
  localparam logic [2:0] S_ALLRED_B  = 3'd6;
  localparam logic [2:0] S_WALK_B    = 3'd7;

  // Lamp vector bit order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
  localparam logic [6:0] LAMP_NS_GREEN  = 7'b1000010;
  localparam logic [6:0] LAMP_NS_YELLOW = 7'b0100010;
  localparam logic [6:0] LAMP_ALLRED    = 7'b0010010;
  localparam logic [6:0] LAMP_WALK      = 7'b0010011;
  localparam logic [6:0] LAMP_EW_GREEN  = 7'b0011000;
  localparam logic [6:0] LAMP_EW_YELLOW = 7'b0010100;

  // True for either pedestrian WALK phase.
  function automatic logic is_walk(input logic [2:0] s);
    return (s == S_WALK_A) || (s == S_WALK_B);
  endfunction

  // Lamp pattern shown while in phase s; unknown codes fall back to NS green.
  function automatic logic [6:0] lamps_of(input logic [2:0] s);
    logic [6:0] v;
    case (s)
      S_NS_GREEN:  v = LAMP_NS_GREEN;
      S_NS_YELLOW: v = LAMP_NS_YELLOW;
      S_ALLRED_A:  v = LAMP_ALLRED;
      S_WALK_A:    v = LAMP_WALK;
      S_EW_GREEN:  v = LAMP_EW_GREEN;
      S_EW_YELLOW: v = LAMP_EW_YELLOW;
      S_ALLRED_B:  v = LAMP_ALLRED;
      S_WALK_B:    v = LAMP_WALK;
      default:     v = LAMP_NS_GREEN;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_2way_phase_timer.sv
// Phase counter: clears on a phase change, otherwise counts up; flags the last
// cycle of the phase and whether the minimum duration has been served.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  input  logic [CNT_W-1:0] min_dur,
  output logic [CNT_W-1:0] cnt,
  output logic             term,
  output logic             min_ok
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Cycles elapsed in the current phase, restarting at 0 on every phase change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // Durations are at least 1, so dur-1 and min_dur-1 never wrap.
  assign cnt    = r_cnt;
  assign term   = (r_cnt == (dur - ONE));
  assign min_ok = (r_cnt >= (min_dur - ONE));

endmodule

// File: rtl/traffic_light_ctrl_2way.sv
// Two-road intersection sequencer with all-red clearance and an optional
// pedestrian WALK phase inserted after the all-red when a request is pending.
module traffic_light_ctrl_2way
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int GREEN_T   = 5,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int MIN_GREEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ped_req,
  output logic             ns_green,
  output logic             ns_yellow,
  output logic             ns_red,
  output logic             ew_green,
  output logic             ew_yellow,
  output logic             ew_red,
  output logic             walk,
  output logic             ped_ack,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [CNT_W-1:0] L_GREEN  = GREEN_T[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_YELLOW = YELLOW_T[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_ALLRED = ALLRED_T[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_WALK   = WALK_T[CNT_W-1:0];
  localparam logic [CNT_W-1:0] L_MIN    = MIN_GREEN[CNT_W-1:0];

  logic [2:0]       r_state;
  logic             r_pending;
  logic             r_ped_ack;
  logic [6:0]       r_lamps;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_dur;
  logic [CNT_W-1:0] w_cnt;
  logic             w_term;
  logic             w_min_ok;
  logic             w_clear;
  logic             w_walk_entry;
  logic             w_green_end;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .dur     (w_dur),
    .min_dur (L_MIN),
    .cnt     (w_cnt),
    .term    (w_term),
    .min_ok  (w_min_ok)
  );

  // Duration of the phase currently being timed.
  always_comb begin
    w_dur = L_GREEN;
    case (r_state)
      S_NS_GREEN, S_EW_GREEN:   w_dur = L_GREEN;
      S_NS_YELLOW, S_EW_YELLOW: w_dur = L_YELLOW;
      S_ALLRED_A, S_ALLRED_B:   w_dur = L_ALLRED;
      S_WALK_A, S_WALK_B:       w_dur = L_WALK;
      default:                  w_dur = L_GREEN;
    endcase
  end

  // A pending pedestrian cuts green short once the minimum green is served.
  assign w_green_end  = w_term || (r_pending && w_min_ok);
  assign w_clear      = (w_state_nxt != r_state);
  assign w_walk_entry = is_walk(w_state_nxt) && !is_walk(r_state);

  // Phase sequencing; WALK is inserted after an all-red only on a pending request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NS_GREEN:  if (w_green_end) w_state_nxt = S_NS_YELLOW; else w_state_nxt = r_state;
      S_NS_YELLOW: if (w_term)      w_state_nxt = S_ALLRED_A;  else w_state_nxt = r_state;
      S_ALLRED_A: begin
        if (w_term) w_state_nxt = r_pending ? S_WALK_A : S_EW_GREEN;
        else        w_state_nxt = r_state;
      end
      S_WALK_A:    if (w_term)      w_state_nxt = S_EW_GREEN;  else w_state_nxt = r_state;
      S_EW_GREEN:  if (w_green_end) w_state_nxt = S_EW_YELLOW; else w_state_nxt = r_state;
      S_EW_YELLOW: if (w_term)      w_state_nxt = S_ALLRED_B;  else w_state_nxt = r_state;
      S_ALLRED_B: begin
        if (w_term) w_state_nxt = r_pending ? S_WALK_B : S_NS_GREEN;
        else        w_state_nxt = r_state;
      end
      S_WALK_B:    if (w_term)      w_state_nxt = S_NS_GREEN;  else w_state_nxt = r_state;
      default:     w_state_nxt = S_NS_GREEN;
    endcase
  end

  // State, pending latch, WALK acknowledge and lamp pattern all register together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_NS_GREEN;
      r_pending <= 1'b0;
      r_ped_ack <= 1'b0;
      r_lamps   <= LAMP_NS_GREEN;
    end else begin
      r_state   <= w_state_nxt;
      r_ped_ack <= w_walk_entry;
      r_lamps   <= lamps_of(w_state_nxt);
      // Entering WALK serves the request; requests seen in WALK are dropped.
      if (w_walk_entry) begin
        r_pending <= 1'b0;
      end else if (ped_req && !is_walk(r_state)) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  assign ns_green  = r_lamps[6];
  assign ns_yellow = r_lamps[5];
  assign ns_red    = r_lamps[4];
  assign ew_green  = r_lamps[3];
  assign ew_yellow = r_lamps[2];
  assign ew_red    = r_lamps[1];
  assign walk      = r_lamps[0];
  assign ped_ack   = r_ped_ack;
  assign phase_cnt = w_cnt;

endmodule

// File: tb/tb_traffic_light_ctrl_2way.sv
// Scoreboard bench: stimulus pushes the hand-derived per-cycle output vector
// {lamps, ped_ack, phase_cnt}; a negedge monitor pops and compares each cycle.
module tb_traffic_light_ctrl_2way;

  localparam int P_NSG = 0;
  localparam int P_NSY = 1;
  localparam int P_AR  = 2;
  localparam int P_WK  = 3;
  localparam int P_EWG = 4;
  localparam int P_EWY = 5;

  logic       clk;
  logic       reset;
  logic       ped_req;
  logic       ns_green, ns_yellow, ns_red;
  logic       ew_green, ew_yellow, ew_red;
  logic       walk, ped_ack;
  logic [3:0] phase_cnt;

  logic [11:0] exp_q[$];
  int          n_cmp;
  int          n_fail;
  logic        inv_en;
  int          cyc;

  traffic_light_ctrl_2way dut (
    .clk       (clk),
    .reset     (reset),
    .ped_req   (ped_req),
    .ns_green  (ns_green),
    .ns_yellow (ns_yellow),
    .ns_red    (ns_red),
    .ew_green  (ew_green),
    .ew_yellow (ew_yellow),
    .ew_red    (ew_red),
    .walk      (walk),
    .ped_ack   (ped_ack),
    .phase_cnt (phase_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected lamps {ns_g,ns_y,ns_r,ew_g,ew_y,ew_r,walk} per phase kind.
  function automatic logic [6:0] exp_lamps(input int ph);
    logic [6:0] v;
    case (ph)
      P_NSG:   v = 7'b1000010;
      P_NSY:   v = 7'b0100010;
      P_AR:    v = 7'b0010010;
      P_WK:    v = 7'b0010011;
      P_EWG:   v = 7'b0011000;
      P_EWY:   v = 7'b0010100;
      default: v = 7'b0000000;
    endcase
    return v;
  endfunction

  // Queue n cycles of phase ph with phase_cnt 0..n-1; ack only in WALK cycle 0.
  task automatic push_phase(input int ph, input int n);
    logic [3:0] c;
    for (int i = 0; i < n; i++) begin
      c = i[3:0];
      exp_q.push_back({exp_lamps(ph), (ph == P_WK) && (i == 0), c});
    end
  endtask

  // One full request-free cycle of the intersection.
  task automatic push_period();
    push_phase(P_NSG, 5); push_phase(P_NSY, 2); push_phase(P_AR, 1);
    push_phase(P_EWG, 5); push_phase(P_EWY, 2); push_phase(P_AR, 1);
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: per-cycle invariants plus scoreboard comparison.
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] expv;
    act = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk, ped_ack, phase_cnt};
    if (inv_en) begin
      n_cmp++;
      if (!$onehot({ns_green, ns_yellow, ns_red}) || !$onehot({ew_green, ew_yellow, ew_red}) ||
          (ns_green && ew_green) || (walk && !(ns_red && ew_red))) begin
        n_fail++;
        $display("FAIL lamp_invariant cyc=%0d: lamps=%b, required one-hot heads/no double green/walk->reds",
                 cyc, act[11:5]);
      end
    end
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      n_cmp++;
      if (act !== expv) begin
        n_fail++;
        $display("FAIL seq_check cyc=%0d: lamps/ack/cnt got %b/%b/%0d, required %b/%b/%0d",
                 cyc, act[11:5], act[4], act[3:0], expv[11:5], expv[4], expv[3:0]);
      end
    end
    cyc++;
  end

  // Stimulus: directed scenarios, each starting at an NS_GREEN cnt=0 cycle.
  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    inv_en  = 1'b0;
    cyc     = 0;
    reset   = 1'b0;
    ped_req = 1'b0;

    // Reset held 3 cycles: outputs show NS green, EW red, cnt 0.
    @(posedge clk); #1; inv_en = 1'b1; push_phase(P_NSG, 1);
    @(posedge clk); #1; push_phase(P_NSG, 1);
    @(posedge clk); #1; reset = 1'b1;
    // Reset-state cycle is NS_GREEN cnt 0; then two request-free periods.
    push_period(); push_period();
    drain(40);

    // Pulse during NS_GREEN cnt 0: green cut to 2, WALK_A, then EW.
    push_phase(P_NSG, 2); push_phase(P_NSY, 2); push_phase(P_AR, 1);
    push_phase(P_WK, 4);  push_phase(P_EWG, 5); push_phase(P_EWY, 2); push_phase(P_AR, 1);
    ped_req = 1'b1;
    @(posedge clk); #1; ped_req = 1'b0;
    drain(30);

    // Request sampled into EW_GREEN cnt 3: EW green lasts 4, then WALK_B.
    push_phase(P_NSG, 5); push_phase(P_NSY, 2); push_phase(P_AR, 1);
    push_phase(P_EWG, 4); push_phase(P_EWY, 2); push_phase(P_AR, 1); push_phase(P_WK, 4);
    repeat (10) begin @(posedge clk); #1; end
    ped_req = 1'b1;
    @(posedge clk); #1; ped_req = 1'b0;
    drain(30);

    // Held through WALK_A and one cycle past it: re-latch gives WALK_B only.
    push_phase(P_NSG, 2); push_phase(P_NSY, 2); push_phase(P_AR, 1); push_phase(P_WK, 4);
    push_phase(P_EWG, 2); push_phase(P_EWY, 2); push_phase(P_AR, 1); push_phase(P_WK, 4);
    ped_req = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    ped_req = 1'b0;
    drain(30);

    // Request latched in EW_YELLOW, then reset: no WALK in the next period.
    push_phase(P_NSG, 5); push_phase(P_NSY, 2); push_phase(P_AR, 1);
    push_phase(P_EWG, 5); push_phase(P_EWY, 2);
    push_period();
    repeat (13) begin @(posedge clk); #1; end
    ped_req = 1'b1;
    @(posedge clk); #1; ped_req = 1'b0; reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound in case the stimulus stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
